// File: rtl/game_ctrl_if.sv
// Game sequencer bundle: player/video inputs into the sequencer and
// game state, score and speed back out to Jump, Ground and the display path.
interface game_ctrl_if;
    logic        start;
    logic        abort;
    logic        vs;
    logic        px_dinosaur;
    logic        px_obstacle;
    logic        game_status;
    logic        crashed;
    logic        frame_tick;
    logic [3:0]  speed;
    logic [13:0] score;

    modport master (
        output start, abort, vs, px_dinosaur, px_obstacle,
        input  game_status, crashed, frame_tick, speed, score
    );

    modport slave (
        input  start, abort, vs, px_dinosaur, px_obstacle,
        output game_status, crashed, frame_tick, speed, score
    );
endinterface

// File: rtl/game_ctrl.sv
// Central sequencer for the dinosaur runner: game state, collision detect,
// score and scroll speed, all updated on the frame boundary (vs falling).
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | attract screen, waiting for start
//  ARMED   | start seen, waiting for the next frame boundary to begin
//  RUNNING | world scrolling, score counting, collisions detected
//  CRASHED | freeze frame / game over, waiting for restart
module game_ctrl #(
    parameter int         SCORE_DIV  = 6,
    parameter int         SPEED_STEP = 100,
    parameter logic [3:0] INIT_SPEED = 4'd1,
    parameter logic [3:0] MAX_SPEED  = 4'd9,
    parameter int         SCORE_MAX  = 9999
) (
    input logic         CLK,
    input logic         clrn,
    game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        CRASHED = 2'd3
    } state_t;

    localparam logic [5:0]  FRAME_LAST = 6'(SCORE_DIV - 1);
    localparam logic [13:0] STEP_LAST  = 14'(SPEED_STEP - 1);
    localparam logic [13:0] SCORE_TOP  = 14'(SCORE_MAX);

    state_t      state;
    state_t      state_nxt;
    logic        vs_q;
    logic        frame_tick_q;
    logic        start_req;
    logic        hit;
    logic [5:0]  frame_cnt;
    logic [13:0] step_cnt;
    logic [13:0] score_q;
    logic [3:0]  speed_q;
    logic        game_status_q;
    logic        crashed_q;

    logic        overlap;
    logic        hit_now;
    logic        run_start;
    logic        score_tick;

    // A collision in the tick cycle itself still belongs to the closing frame.
    assign overlap    = bus.px_dinosaur & bus.px_obstacle;
    assign hit_now    = hit | overlap;
    assign run_start  = (state == ARMED) & frame_tick_q & ~bus.abort;
    assign score_tick = (state == RUNNING) & frame_tick_q & ~hit_now & ~bus.abort;

    // State register.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides everything else.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start | start_req) state_nxt = ARMED;
                ARMED:   if (frame_tick_q) state_nxt = RUNNING;
                RUNNING: if (frame_tick_q & hit_now) state_nxt = CRASHED;
                CRASHED: if (bus.start) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame boundary detect, registered state flags, start latch and hit flag.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            vs_q          <= 1'b1;
            frame_tick_q  <= 1'b0;
            game_status_q <= 1'b0;
            crashed_q     <= 1'b0;
            start_req     <= 1'b0;
            hit           <= 1'b0;
        end else begin
            vs_q          <= bus.vs;
            frame_tick_q  <= vs_q & ~bus.vs;
            game_status_q <= (state_nxt == RUNNING);
            crashed_q     <= (state_nxt == CRASHED);

            if (bus.abort) begin
                start_req <= 1'b0;
            end else if (((state == IDLE) || (state == CRASHED)) && bus.start) begin
                start_req <= 1'b1;
            end else if ((state == ARMED) && frame_tick_q) begin
                start_req <= 1'b0;
            end

            if (bus.abort || (state != RUNNING) || frame_tick_q) begin
                hit <= 1'b0;
            end else if (overlap) begin
                hit <= 1'b1;
            end
        end
    end

    // Score and speed scheduling; a crashing tick leaves all counters untouched.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            frame_cnt <= '0;
            step_cnt  <= '0;
            score_q   <= '0;
            speed_q   <= INIT_SPEED;
        end else if (run_start) begin
            frame_cnt <= '0;
            step_cnt  <= '0;
            score_q   <= '0;
            speed_q   <= INIT_SPEED;
        end else if (score_tick) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                // Saturated score also freezes the speed schedule.
                if (score_q != SCORE_TOP) begin
                    score_q <= score_q + 14'd1;
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        if (speed_q < MAX_SPEED) begin
                            speed_q <= speed_q + 4'd1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 14'd1;
                    end
                end
            end else begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    assign bus.game_status = game_status_q;
    assign bus.crashed     = crashed_q;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.speed       = speed_q;
    assign bus.score       = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a default instance plus a small-parameter
// instance (div 1, step 2, max speed 2, max score 5) sharing the same stimulus
// so saturation and the speed cap are reached within a short run.
module tb_game_ctrl;

    logic CLK  = 1'b0;
    logic clrn = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic vs = 1'b1;
    logic px_d = 1'b0;
    logic px_o = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    game_ctrl_if bus();
    game_ctrl_if bus2();

    assign bus.start        = start;
    assign bus.abort        = abort;
    assign bus.vs           = vs;
    assign bus.px_dinosaur  = px_d;
    assign bus.px_obstacle  = px_o;
    assign bus2.start       = start;
    assign bus2.abort       = abort;
    assign bus2.vs          = vs;
    assign bus2.px_dinosaur = px_d;
    assign bus2.px_obstacle = px_o;

    game_ctrl dut (
        .CLK  (CLK),
        .clrn (clrn),
        .bus  (bus)
    );

    game_ctrl #(
        .SCORE_DIV  (1),
        .SPEED_STEP (2),
        .INIT_SPEED (4'd1),
        .MAX_SPEED  (4'd2),
        .SCORE_MAX  (5)
    ) dut_sat (
        .CLK  (CLK),
        .clrn (clrn),
        .bus  (bus2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // One 4-cycle frame per iteration: vs low one cycle, tick pulses next cycle.
    task automatic frame_t(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            cyc();
            vs = 1'b1;
            cyc();
            cyc();
            cyc();
        end
    endtask

    initial begin
        // Reset values
        #3 clrn = 1'b0;
        cyc();
        cyc();
        chk("rst_status", 16'(bus.game_status), 16'd0);
        chk("rst_crashed", 16'(bus.crashed), 16'd0);
        chk("rst_tick", 16'(bus.frame_tick), 16'd0);
        chk("rst_speed", 16'(bus.speed), 16'd1);
        chk("rst_score", 16'(bus.score), 16'd0);
        chk("rst_score_sat", 16'(bus2.score), 16'd0);
        clrn = 1'b1;
        cyc();

        // Tick generation: one pulse per falling edge, none while held low
        vs = 1'b0;
        cyc();
        chk("tick_pulse", 16'(bus.frame_tick), 16'd1);
        cyc();
        chk("tick_held_low", 16'(bus.frame_tick), 16'd0);
        cyc();
        vs = 1'b1;
        cyc();

        // T1: idle frames without start
        frame_t(5);
        chk("t1_status", 16'(bus.game_status), 16'd0);
        chk("t1_score", 16'(bus.score), 16'd0);
        chk("t1_speed", 16'(bus.speed), 16'd1);

        // T2: start mid-frame, run begins one CLK after the next tick
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t2_armed_status", 16'(bus.game_status), 16'd0);
        vs = 1'b0;
        cyc();
        chk("t2_tick", 16'(bus.frame_tick), 16'd1);
        chk("t2_status_at_tick", 16'(bus.game_status), 16'd0);
        vs = 1'b1;
        cyc();
        chk("t2_status_run", 16'(bus.game_status), 16'd1);
        chk("t2_score0", 16'(bus.score), 16'd0);
        cyc();
        cyc();
        frame_t(1);
        chk("t2_sat_score1", 16'(bus2.score), 16'd1);
        chk("t2_sat_speed1", 16'(bus2.speed), 16'd1);
        frame_t(1);
        chk("t2_sat_score2", 16'(bus2.score), 16'd2);
        chk("t2_sat_speed2", 16'(bus2.speed), 16'd2);
        frame_t(3);
        chk("t2_score_5ticks", 16'(bus.score), 16'd0);
        chk("t2_sat_score5", 16'(bus2.score), 16'd5);
        frame_t(1);
        chk("t2_score_6ticks", 16'(bus.score), 16'd1);
        frame_t(593);
        chk("t2_score_599", 16'(bus.score), 16'd99);
        chk("t2_speed_599", 16'(bus.speed), 16'd1);
        frame_t(1);
        chk("t2_score_600", 16'(bus.score), 16'd100);
        chk("t2_speed_600", 16'(bus.speed), 16'd2);
        chk("t2_sat_score_hold", 16'(bus2.score), 16'd5);
        chk("t2_sat_speed_cap", 16'(bus2.speed), 16'd2);

        // T3: mid-frame collision, crash on the wrap tick must not score
        frame_t(5);
        px_d = 1'b1;
        px_o = 1'b1;
        cyc();
        px_d = 1'b0;
        px_o = 1'b0;
        chk("t3_pending_crashed", 16'(bus.crashed), 16'd0);
        chk("t3_pending_status", 16'(bus.game_status), 16'd1);
        cyc();
        vs = 1'b0;
        cyc();
        vs = 1'b1;
        cyc();
        chk("t3_crashed", 16'(bus.crashed), 16'd1);
        chk("t3_status", 16'(bus.game_status), 16'd0);
        chk("t3_score_frozen", 16'(bus.score), 16'd100);
        frame_t(3);
        chk("t3_crash_hold", 16'(bus.crashed), 16'd1);
        chk("t3_score_hold", 16'(bus.score), 16'd100);
        chk("t3_speed_hold", 16'(bus.speed), 16'd2);

        // T4: restart, values held until the run begins
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_armed_crashed", 16'(bus.crashed), 16'd0);
        chk("t4_armed_score", 16'(bus.score), 16'd100);
        frame_t(1);
        chk("t4_run_status", 16'(bus.game_status), 16'd1);
        chk("t4_run_score", 16'(bus.score), 16'd0);
        chk("t4_run_speed", 16'(bus.speed), 16'd1);
        // overlap only in the tick cycle
        vs = 1'b0;
        cyc();
        px_d = 1'b1;
        px_o = 1'b1;
        vs = 1'b1;
        cyc();
        px_d = 1'b0;
        px_o = 1'b0;
        chk("t4_tick_overlap", 16'(bus.crashed), 16'd1);
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        frame_t(1);
        chk("t4_restart", 16'(bus.game_status), 16'd1);
        // overlap in the cycle after the tick
        vs = 1'b0;
        cyc();
        vs = 1'b1;
        cyc();
        px_d = 1'b1;
        px_o = 1'b1;
        cyc();
        px_d = 1'b0;
        px_o = 1'b0;
        cyc();
        chk("t4_late_overlap_wait", 16'(bus.crashed), 16'd0);
        frame_t(1);
        chk("t4_late_overlap_crash", 16'(bus.crashed), 16'd1);
        // overlap while ARMED is ignored
        start = 1'b1;
        cyc();
        start = 1'b0;
        px_d = 1'b1;
        px_o = 1'b1;
        cyc();
        px_d = 1'b0;
        px_o = 1'b0;
        frame_t(1);
        frame_t(1);
        chk("t4_armed_ignore_crashed", 16'(bus.crashed), 16'd0);
        chk("t4_armed_ignore_status", 16'(bus.game_status), 16'd1);
        frame_t(5);
        chk("t4_score1", 16'(bus.score), 16'd1);
        px_d = 1'b1;
        px_o = 1'b1;
        cyc();
        px_d = 1'b0;
        px_o = 1'b0;
        frame_t(1);
        chk("t4_crash_again", 16'(bus.crashed), 16'd1);

        // T6: abort beats start while CRASHED; score and speed held
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        chk("t6_abort_status", 16'(bus.game_status), 16'd0);
        chk("t6_abort_crashed", 16'(bus.crashed), 16'd0);
        chk("t6_abort_score", 16'(bus.score), 16'd1);
        chk("t6_abort_sat_score", 16'(bus2.score), 16'd5);
        chk("t6_abort_sat_speed", 16'(bus2.speed), 16'd2);
        frame_t(1);
        chk("t6_stays_idle", 16'(bus.game_status), 16'd0);

        // T5: long run, saturating instance must hold its ceiling
        start = 1'b1;
        cyc();
        start = 1'b0;
        frame_t(1);
        chk("t5_run_status", 16'(bus.game_status), 16'd1);
        frame_t(2000);
        chk("t5_score_2000", 16'(bus.score), 16'd333);
        chk("t5_speed_2000", 16'(bus.speed), 16'd4);
        chk("t5_sat_score", 16'(bus2.score), 16'd5);
        chk("t5_sat_speed", 16'(bus2.speed), 16'd2);

        // T6: asynchronous reset mid-run
        #2 clrn = 1'b0;
        #1;
        chk("t6_rst_status", 16'(bus.game_status), 16'd0);
        chk("t6_rst_crashed", 16'(bus.crashed), 16'd0);
        chk("t6_rst_tick", 16'(bus.frame_tick), 16'd0);
        chk("t6_rst_speed", 16'(bus.speed), 16'd1);
        chk("t6_rst_score", 16'(bus.score), 16'd0);
        chk("t6_rst_sat_score", 16'(bus2.score), 16'd0);

        // vs low at reset release yields exactly one tick
        vs = 1'b0;
        cyc();
        clrn = 1'b1;
        cyc();
        chk("rel_tick", 16'(bus.frame_tick), 16'd1);
        vs = 1'b1;
        cyc();
        chk("rel_tick_end", 16'(bus.frame_tick), 16'd0);
        chk("rel_status", 16'(bus.game_status), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
